// File: rtl/attn_pkg.sv
// rtl/attn_pkg.sv - shared geometry, FSM encoding and drain beat layout for the attention output collector
package attn_pkg;
  localparam int ROWS    = 4;
  localparam int GROUPS  = 32;
  localparam int WORD_W  = 128;
  localparam int OADDR_W = 7;

  typedef enum logic [2:0] {IDLE, COLLECT, DRAIN, FLUSH, DONE} collect_state_t;

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic [1:0]        row;
    logic [4:0]        group;
    logic              last;
  } drain_beat_t;

  function automatic logic [OADDR_W-1:0] oaddr(input logic [1:0] row, input logic [4:0] group);
    return {row, group};
  endfunction
endpackage

// File: rtl/attn_out_fifo.sv
// rtl/attn_out_fifo.sv - synchronous skid FIFO holding returned drain beats
module attn_out_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           din,
  input  logic                       pop,
  output logic [WIDTH-1:0]           dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/attn_out_collect.sv
// rtl/attn_out_collect.sv - scoreboarded capture of attention output into SRAM, then row-major credit-based drain
module attn_out_collect
  import attn_pkg::*;
#(
  parameter int READ_LAT   = 2,
  parameter int FIFO_DEPTH = READ_LAT + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               in_valid,
  input  logic [1:0]         in_row,
  input  logic [4:0]         in_group,
  input  logic [WORD_W-1:0]  in_data,
  output logic [OADDR_W-1:0] O_mem_addr,
  output logic               O_mem_wen,
  output logic               O_mem_ren,
  output logic [WORD_W-1:0]  O_mem_din,
  input  logic [WORD_W-1:0]  O_mem_out,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [WORD_W-1:0]  m_data,
  output logic [1:0]         m_row,
  output logic [4:0]         m_group,
  output logic               m_last,
  output logic               busy,
  output logic               done,
  output logic               err_dup,
  output logic               err_drop
);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  collect_state_t             state;
  logic                       start_q;
  logic [ROWS*GROUPS-1:0]     sb;
  logic [7:0]                 uniq_cnt;
  logic [OADDR_W-1:0]         rd_ptr;
  logic [READ_LAT-1:0]        pipe_vld;
  logic [OADDR_W-1:0]         pipe_tag [READ_LAT];
  logic [OADDR_W-1:0]         wr_addr;
  logic [OADDR_W-1:0]         ret_tag;
  drain_beat_t                push_beat;
  drain_beat_t                head_beat;
  logic                       push;
  logic                       pop;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic [CNT_W-1:0]           fifo_count;
  logic [7:0]                 occupancy;
  logic                       issue;

  assign wr_addr = oaddr(in_row, in_group);
  assign ret_tag = pipe_tag[READ_LAT-1];
  assign push    = pipe_vld[READ_LAT-1];
  assign push_beat = '{data: O_mem_out, row: ret_tag[6:5], group: ret_tag[4:0], last: &ret_tag};

  assign m_valid = ~fifo_empty;
  assign pop     = m_valid & m_ready;
  assign m_data  = m_valid ? head_beat.data  : '0;
  assign m_row   = m_valid ? head_beat.row   : '0;
  assign m_group = m_valid ? head_beat.group : '0;
  assign m_last  = m_valid & head_beat.last;
  assign busy    = (state != IDLE);

  // Entries already queued plus reads still in the SRAM pipe; a pop this cycle frees a slot.
  assign occupancy = 8'(fifo_count) + 8'($countones(pipe_vld));
  assign issue     = (state == DRAIN) && (occupancy < 8'(FIFO_DEPTH) + 8'(pop));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      start_q    <= 1'b0;
      sb         <= '0;
      uniq_cnt   <= '0;
      rd_ptr     <= '0;
      err_dup    <= 1'b0;
      err_drop   <= 1'b0;
      done       <= 1'b0;
      O_mem_addr <= '0;
      O_mem_wen  <= 1'b0;
      O_mem_ren  <= 1'b0;
      O_mem_din  <= '0;
    end else begin
      start_q   <= start;
      done      <= 1'b0;
      O_mem_wen <= 1'b0;
      O_mem_ren <= 1'b0;
      if (in_valid && state != COLLECT) err_drop <= 1'b1;
      case (state)
        IDLE: begin
          if (start && !start_q) begin
            sb       <= '0;
            uniq_cnt <= '0;
            rd_ptr   <= '0;
            err_dup  <= 1'b0;
            err_drop <= 1'b0;
            state    <= COLLECT;
          end
        end
        COLLECT: begin
          if (in_valid) begin
            O_mem_wen  <= 1'b1;
            O_mem_addr <= wr_addr;
            O_mem_din  <= in_data;
            if (sb[wr_addr]) begin
              err_dup <= 1'b1;
            end else begin
              sb[wr_addr] <= 1'b1;
              uniq_cnt    <= uniq_cnt + 8'd1;
              if (uniq_cnt == 8'd127) state <= DRAIN;
            end
          end
        end
        DRAIN: begin
          if (issue) begin
            O_mem_ren  <= 1'b1;
            O_mem_addr <= rd_ptr;
            rd_ptr     <= rd_ptr + 1'b1;
            if (&rd_ptr) state <= FLUSH;
          end
        end
        FLUSH: begin
          if (pop && head_beat.last) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_vld <= '0;
      for (int i = 0; i < READ_LAT; i++) pipe_tag[i] <= '0;
    end else begin
      pipe_vld[0] <= issue;
      pipe_tag[0] <= rd_ptr;
      for (int i = 1; i < READ_LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_tag[i] <= pipe_tag[i-1];
      end
    end
  end

  attn_out_fifo #(.WIDTH($bits(drain_beat_t)), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (push_beat),
    .pop   (pop),
    .dout  (head_beat),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Credit accounting guarantees a returning read always finds a free slot.
  assert property (@(posedge clk) disable iff (!rst_n) !(push && fifo_full && !pop));
endmodule
